// File: rtl/pipe_fetch_decode_pkg.sv
// Shared types, field layout and function codes for the fetch/decode front end.
// The optional read-after-write stall is enabled with PIPE_HAZARD_STALL_EN.
package pipe_pkg;
    localparam int IMEM_DEPTH = 256;
    localparam int INSTR_W    = 24;
    localparam int PC_W       = $clog2(IMEM_DEPTH);
    localparam int HAZ_DEPTH  = 2;

    localparam logic [3:0] FUNC_ADD  = 4'd0;
    localparam logic [3:0] FUNC_SUB  = 4'd1;
    localparam logic [3:0] FUNC_MUL  = 4'd2;
    localparam logic [3:0] FUNC_AND  = 4'd3;
    localparam logic [3:0] FUNC_OR   = 4'd4;
    localparam logic [3:0] FUNC_HALT = 4'd15;

    localparam int FUNC_MSB = 23;
    localparam int FUNC_LSB = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 16;
    localparam int RS_MSB   = 15;
    localparam int RS_LSB   = 12;
    localparam int RS1_MSB  = 11;
    localparam int RS1_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rs1;
        logic [7:0] addr;
    } decoded_t;

    function automatic decoded_t decode(input logic [INSTR_W-1:0] w);
        decoded_t d;
        d.func = w[FUNC_MSB:FUNC_LSB];
        d.rd   = w[RD_MSB:RD_LSB];
        d.rs   = w[RS_MSB:RS_LSB];
        d.rs1  = w[RS1_MSB:RS1_LSB];
        d.addr = w[ADDR_MSB:ADDR_LSB];
        return d;
    endfunction
endpackage

// File: rtl/pipe_fetch_decode_if.sv
// Control, programming and decoded-output bundle of the fetch/decode front end.
// master drives start/programming/out_ready; slave is the front end itself.
interface pipe_fetch_decode_if;
    import pipe_pkg::*;

    logic               start;
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               out_ready;
    logic               out_valid;
    logic [3:0]         func;
    logic [3:0]         rd;
    logic [3:0]         rs;
    logic [3:0]         rs1;
    logic [7:0]         addr;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic               busy;

    modport master (
        output start, prog_we, prog_addr, prog_data, out_ready,
        input  out_valid, func, rd, rs, rs1, addr, pc, halted, busy
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, out_ready,
        output out_valid, func, rd, rs, rs1, addr, pc, halted, busy
    );
endinterface

// File: rtl/pipe_fetch_decode_hazard_sb.sv
// Destination-register scoreboard: remembers the rd of the last DEPTH fetch slots.
// Only built when PIPE_HAZARD_STALL_EN is defined, since nothing else uses it.
`ifdef PIPE_HAZARD_STALL_EN
module pipe_hazard_sb
    import pipe_pkg::*;
#(
    parameter int DEPTH = HAZ_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic       push_valid_i,
    input  logic [3:0] push_rd_i,
    input  logic [3:0] rs_i,
    input  logic [3:0] rs1_i,
    output logic       hit_o
);
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DEPTH-1:0][3:0] rd_q, rd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
        end
    end

    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        if (clear_i) begin
            vld_d = '0;
        end else if (shift_i) begin
            vld_d[0] = push_valid_i;
            rd_d[0]  = push_rd_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
        end
    end

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_q[i] == rs_i || rd_q[i] == rs1_i)) hit_o = 1'b1;
        end
    end
endmodule
`endif

// File: rtl/pipe_fetch_decode.sv
// Instruction memory, program counter and decode register feeding the register-read stage.
// Defining PIPE_HAZARD_STALL_EN adds read-after-write bubbles via pipe_hazard_sb.
//
// state | meaning
// IDLE  | after reset; programming allowed, waits for start
// RUN   | fetching and issuing one word per fetch slot
// HALT  | HALT opcode fetched; programming allowed, start restarts at pc 0
module pipe_fetch_decode
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pipe_fetch_decode_if.slave bus
);
    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    decoded_t           fld_q, fld_d;
    logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

    logic [INSTR_W-1:0] instr;
    decoded_t           dec;
    logic               start_ok, fetch_slot, is_halt, stall, issue;

    assign start_ok   = bus.start && (state_q != S_RUN);
    assign fetch_slot = (state_q == S_RUN) && (bus.out_ready || !valid_q);
    assign instr      = imem_q[pc_q];
    assign dec        = decode(instr);
    assign is_halt    = (dec.func == FUNC_HALT);
    assign issue      = fetch_slot && !is_halt && !stall;

`ifdef PIPE_HAZARD_STALL_EN
    pipe_hazard_sb #(.DEPTH(HAZ_DEPTH)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .shift_i      (fetch_slot),
        .push_valid_i (issue),
        .push_rd_i    (dec.rd),
        .rs_i         (dec.rs),
        .rs1_i        (dec.rs1),
        .hit_o        (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Memory is deliberately not reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q != S_RUN) imem_q[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fld_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fld_q    <= fld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (fetch_slot && is_halt) state_d = S_HALT;
            S_HALT:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fld_d    = fld_q;
        if (start_ok) begin
            pc_d     = '0;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end else if (fetch_slot) begin
            if (is_halt) begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else if (stall) begin
                valid_d = 1'b0;
            end else begin
                fld_d   = dec;
                valid_d = 1'b1;
                pc_d    = pc_q + PC_W'(1);
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.func      = fld_q.func;
    assign bus.rd        = fld_q.rd;
    assign bus.rs        = fld_q.rs;
    assign bus.rs1       = fld_q.rs1;
    assign bus.addr      = fld_q.addr;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.busy      = (state_q == S_RUN);
endmodule
